fc_argmax: RTL and testbench

//  Classifier back end of the binary CNN accelerator. Consumes the N_CLASS signed

---
 rtl/fc_argmax.sv | 131 +++++++++++++
 tb/tb_fc_argmax.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fc_argmax.sv
// Sequential argmax over the FC layer's signed class scores, one compare per cycle.
// Define FC_ARGMAX_SCORE_EN to also export the winning score on class_score.
module fc_argmax #(
  parameter int N_CLASS = 10,
  parameter int SCORE_W = 17,
  parameter int IDX_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fc_valid,
  output logic                       fc_ready,
  input  logic [N_CLASS*SCORE_W-1:0] fc_scores,
  output logic                       class_out_valid,
  input  logic                       class_out_ready,
  output logic [IDX_W-1:0]           class_out,
  output logic                       busy
`ifdef FC_ARGMAX_SCORE_EN
  ,
  output logic signed [SCORE_W-1:0]  class_score
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                    state_r;
  logic signed [SCORE_W-1:0] bank_r [N_CLASS];
  logic signed [SCORE_W-1:0] max_r;
  logic [IDX_W-1:0]          idx_r;
  logic [IDX_W-1:0]          k_r;

  logic                      last_s;
  logic                      gt_s;
  logic signed [SCORE_W-1:0] next_max_s;
  logic [IDX_W-1:0]          next_idx_s;

  assign last_s = (k_r == IDX_W'(N_CLASS - 1));

  // Strict signed compare of the current bank entry against the running max.
  always_comb begin
    gt_s       = 1'b0;
    next_max_s = max_r;
    next_idx_s = idx_r;
    if (state_r == SCAN) begin
      gt_s = (bank_r[k_r] > max_r);
      if (gt_s) begin
        next_max_s = bank_r[k_r];
        next_idx_s = k_r;
      end else begin
        next_max_s = max_r;
        next_idx_s = idx_r;
      end
    end else begin
      gt_s = 1'b0;
    end
  end

  // Control FSM, score bank and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      fc_ready        <= 1'b1;
      class_out_valid <= 1'b0;
      class_out       <= '0;
      busy            <= 1'b0;
      max_r           <= '0;
      idx_r           <= '0;
      k_r             <= '0;
      for (int i = 0; i < N_CLASS; i++) bank_r[i] <= '0;
`ifdef FC_ARGMAX_SCORE_EN
      class_score     <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (fc_valid) begin
            for (int i = 0; i < N_CLASS; i++) bank_r[i] <= fc_scores[i*SCORE_W +: SCORE_W];
            max_r    <= fc_scores[SCORE_W-1:0];
            idx_r    <= '0;
            fc_ready <= 1'b0;
            busy     <= 1'b1;
            if (N_CLASS == 1) begin
              // Single class: the only score is trivially the winner.
              state_r         <= HOLD;
              class_out_valid <= 1'b1;
              class_out       <= '0;
`ifdef FC_ARGMAX_SCORE_EN
              class_score     <= fc_scores[SCORE_W-1:0];
`endif
            end else begin
              state_r <= SCAN;
              k_r     <= IDX_W'(1);
            end
          end
        end
        SCAN: begin
          max_r <= next_max_s;
          idx_r <= next_idx_s;
          if (last_s) begin
            state_r         <= HOLD;
            class_out_valid <= 1'b1;
            class_out       <= next_idx_s;
`ifdef FC_ARGMAX_SCORE_EN
            class_score     <= next_max_s;
`endif
          end else begin
            k_r <= k_r + IDX_W'(1);
          end
        end
        HOLD: begin
          if (class_out_ready) begin
            state_r         <= IDLE;
            class_out_valid <= 1'b0;
            fc_ready        <= 1'b1;
            busy            <= 1'b0;
          end
        end
        default: begin
          state_r         <= IDLE;
          fc_ready        <= 1'b1;
          class_out_valid <= 1'b0;
          busy            <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Directed self-checking bench for fc_argmax with hand-computed winners.
`timescale 1ns/1ps
module tb_fc_argmax;
  localparam int N  = 10;
  localparam int W  = 17;
  localparam int IW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             fc_valid;
  logic             fc_ready;
  logic [N*W-1:0]   fc_scores;
  logic             class_out_valid;
  logic             class_out_ready;
  logic [IW-1:0]    class_out;
  logic             busy;
`ifdef FC_ARGMAX_SCORE_EN
  logic signed [W-1:0] class_score;
`endif

  int checks = 0;
  int errors = 0;
  logic signed [W-1:0] sc [N];

  fc_argmax #(.N_CLASS(N), .SCORE_W(W), .IDX_W(IW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fc_valid        (fc_valid),
    .fc_ready        (fc_ready),
    .fc_scores       (fc_scores),
    .class_out_valid (class_out_valid),
    .class_out_ready (class_out_ready),
    .class_out       (class_out),
    .busy            (busy)
`ifdef FC_ARGMAX_SCORE_EN
    ,
    .class_score     (class_score)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic signed [W-1:0] v);
    for (int i = 0; i < N; i++) sc[i] = v;
  endtask

  // Present sc[] for one cycle; the handshake lands on the next rising edge.
  task automatic accept(input string tag);
    @(negedge clk);
    check_value({tag, "_fc_ready"}, {31'd0, fc_ready}, 32'sd1);
    fc_valid = 1'b1;
    for (int i = 0; i < N; i++) fc_scores[i*W +: W] = sc[i];
    @(posedge clk);
    #1;
    fc_valid = 1'b0;
    check_value({tag, "_busy"}, {31'd0, busy}, 32'sd1);
  endtask

  task automatic wait_result(input string tag, input int exp_idx);
    int cnt;
    cnt = 0;
    while (!class_out_valid && cnt < 50) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_value({tag, "_latency"}, cnt, 32'sd9);
    check_value({tag, "_class"}, {28'd0, class_out}, exp_idx);
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    class_out_ready = 1'b1;
    @(posedge clk);
    #1;
    class_out_ready = 1'b0;
    check_value({tag, "_valid_drop"}, {31'd0, class_out_valid}, 32'sd0);
    check_value({tag, "_ready_back"}, {31'd0, fc_ready}, 32'sd1);
  endtask

  initial begin
    int bad_valid, bad_class, bad_ready;
    rst_n = 1'b0;
    fc_valid = 1'b0;
    fc_scores = '0;
    class_out_ready = 1'b0;
    #12;
    check_value("rst_fc_ready", {31'd0, fc_ready}, 32'sd1);
    check_value("rst_valid", {31'd0, class_out_valid}, 32'sd0);
    check_value("rst_class", {28'd0, class_out}, 32'sd0);
    check_value("rst_busy", {31'd0, busy}, 32'sd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: plain maximum
    fill(17'sd0);
    sc[0] = 17'sd5; sc[1] = -17'sd3; sc[2] = 17'sd100; sc[3] = 17'sd7;
    accept("t1");
    wait_result("t1", 2);
    release_result("t1");

    // 2: all negative, signed compare
    fill(-17'sd20);
    sc[7] = -17'sd1;
    accept("t2");
    wait_result("t2", 7);
    release_result("t2");

    // 3: tie goes to the lower index
    fill(17'sd1);
    sc[3] = 17'sd50; sc[8] = 17'sd50;
    accept("t3");
    wait_result("t3", 3);
    release_result("t3");

    // 4: back-pressure in HOLD with a competing image offered
    fill(17'sd0);
    sc[5] = 17'sd1000;
    accept("t4");
    wait_result("t4", 5);
    bad_valid = 0; bad_class = 0; bad_ready = 0;
    fc_valid = 1'b1;
    for (int i = 0; i < N; i++) fc_scores[i*W +: W] = (i == 1) ? 17'sd2000 : 17'sd0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (class_out_valid !== 1'b1) bad_valid++;
      if (class_out !== 4'd5) bad_class++;
      if (fc_ready !== 1'b0) bad_ready++;
    end
    fc_valid = 1'b0;
    check_value("t4_valid_stable", bad_valid, 32'sd0);
    check_value("t4_class_stable", bad_class, 32'sd0);
    check_value("t4_fc_ready_low", bad_ready, 32'sd0);
    release_result("t4");
    repeat (3) @(posedge clk);
    #1;
    check_value("t4_no_new_image", {31'd0, busy}, 32'sd0);

    // 5: reset in the middle of SCAN (k=4), then a fresh image
    fill(17'sd0);
    sc[2] = 17'sd30;
    accept("t5a");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_value("t5_rst_fc_ready", {31'd0, fc_ready}, 32'sd1);
    check_value("t5_rst_valid", {31'd0, class_out_valid}, 32'sd0);
    check_value("t5_rst_busy", {31'd0, busy}, 32'sd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_value("t5_no_stale_result", {31'd0, class_out_valid}, 32'sd0);
    fill(17'sd0);
    sc[9] = 17'sd65535;
    accept("t5b");
    wait_result("t5b", 9);
    release_result("t5b");

    // 6: all most-negative, then a back-to-back image after one bubble
    fill(17'h10000);
    accept("t6");
    wait_result("t6", 0);
`ifdef FC_ARGMAX_SCORE_EN
    check_value("t6_class_score", class_score, -32'sd65536);
`endif
    release_result("t6");
    fill(17'sd4);
    sc[6] = 17'sd9;
    accept("t6_b2b");
    wait_result("t6_b2b", 6);
`ifdef FC_ARGMAX_SCORE_EN
    check_value("t6_b2b_score", class_score, 32'sd9);
`endif
    release_result("t6_b2b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
